// File: rtl/cascade_strobe_divider.sv
// Cascaded clock-enable divider chain: each stage counts the terminal strobes of the one before
// and emits a one-cycle strobe plus a registered ~50% duty phase signal.
module cascade_strobe_divider #(
  parameter int unsigned NUM_STAGES  = 3,
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned DEFAULT_DIV = 16
) (
  input  logic                        clk_in,
  input  logic                        reset_n,
  input  logic                        enable,
  input  logic                        sync_clear,
  input  logic [NUM_STAGES*WIDTH-1:0] div_in,
  input  logic                        div_load,
  output logic [NUM_STAGES-1:0]       strobe_out,
  output logic [NUM_STAGES-1:0]       phase_out
);

  localparam logic [WIDTH-1:0] DefDiv = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] DefCnt = WIDTH'(DEFAULT_DIV - 1);

  logic [NUM_STAGES-1:0][WIDTH-1:0] pend_q, pend_d;
  logic [NUM_STAGES-1:0][WIDTH-1:0] act_q, act_d;
  logic [NUM_STAGES-1:0][WIDTH-1:0] cnt_q, cnt_d;
  logic [NUM_STAGES-1:0][WIDTH-1:0] src;
  logic [NUM_STAGES-1:0]            phase_q, phase_d;
  logic [NUM_STAGES-1:0]            tick;
  logic [NUM_STAGES-1:0]            wrap;

  // A divisor of 0 behaves as 1 so the reload value never underflows.
  function automatic logic [WIDTH-1:0] eff_div(input logic [WIDTH-1:0] d);
    return (d == '0) ? WIDTH'(1) : d;
  endfunction

  // Ripple-enable chain kept in one process so the whole cascade settles in the same cycle.
  always_comb begin
    logic carry;
    carry = enable;
    tick  = '0;
    wrap  = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      tick[k] = carry;
      wrap[k] = carry & (cnt_q[k] == '0) & ~sync_clear & reset_n;
      carry   = wrap[k];
    end
  end

  always_comb begin
    pend_d  = pend_q;
    act_d   = act_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    src     = pend_q;
    for (int k = 0; k < NUM_STAGES; k++) begin
      // A load in the same cycle as a reload wins over the stale pending value.
      src[k]    = div_load ? div_in[k*WIDTH +: WIDTH] : pend_q[k];
      pend_d[k] = src[k];
      if (sync_clear || wrap[k]) begin
        act_d[k] = src[k];
        cnt_d[k] = eff_div(src[k]) - WIDTH'(1);
      end else if (tick[k]) begin
        cnt_d[k] = cnt_q[k] - WIDTH'(1);
      end
      phase_d[k] = (cnt_d[k] >= (eff_div(act_d[k]) >> 1));
    end
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      pend_q  <= {NUM_STAGES{DefDiv}};
      act_q   <= {NUM_STAGES{DefDiv}};
      cnt_q   <= {NUM_STAGES{DefCnt}};
      phase_q <= '1;
    end else begin
      pend_q  <= pend_d;
      act_q   <= act_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign strobe_out = wrap;
  assign phase_out  = phase_q;

endmodule

// File: tb/tb_cascade_strobe_divider.sv
// Directed bench for cascade_strobe_divider with three 8-bit stages defaulting to divide-by-4.
module tb_cascade_strobe_divider;

  localparam int unsigned NS = 3;
  localparam int unsigned W  = 8;

  logic          clk_in = 1'b0;
  logic          reset_n;
  logic          enable;
  logic          sync_clear;
  logic          div_load;
  logic [NS*W-1:0] div_in;
  logic [NS-1:0] strobe_out;
  logic [NS-1:0] phase_out;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_in = ~clk_in;

  cascade_strobe_divider #(
    .NUM_STAGES (NS),
    .WIDTH      (W),
    .DEFAULT_DIV(4)
  ) dut (
    .clk_in    (clk_in),
    .reset_n   (reset_n),
    .enable    (enable),
    .sync_clear(sync_clear),
    .div_in    (div_in),
    .div_load  (div_load),
    .strobe_out(strobe_out),
    .phase_out (phase_out)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] outs();
    return {2'b00, strobe_out, phase_out};
  endfunction

  // Expected {strobe, phase} e cycles into a freshly aligned divide-by-4 chain.
  function automatic logic [7:0] aligned(input int e);
    logic [2:0] s;
    logic [2:0] p;
    s[0] = (e % 4 == 3);
    s[1] = (e % 16 == 15);
    s[2] = (e % 64 == 63);
    p[0] = (e % 4 < 2);
    p[1] = ((e / 4) % 4 < 2);
    p[2] = ((e / 16) % 4 < 2);
    return {2'b00, s, p};
  endfunction

  task automatic next_cycle();
    @(posedge clk_in);
    #1;
  endtask

  task automatic sample();
    @(negedge clk_in);
  endtask

  initial begin
    logic [10:0] s0_exp;
    logic [10:0] p0_exp;
    logic [7:0]  d2_exp [4];
    logic        s;

    reset_n = 1'b1; enable = 1'b1; sync_clear = 1'b0; div_load = 1'b0;
    div_in  = {8'd4, 8'd4, 8'd4};
    #1 reset_n = 1'b0;
    #2 check("reset_async", outs(), 8'b00_000_111);
    next_cycle();
    check("reset_clocked", outs(), 8'b00_000_111);
    reset_n = 1'b1;

    // Free run: stage strobes every 4/16/64 cycles, phases 1,1,0,0.
    for (int e = 0; e < 64; e++) begin
      sample();
      check("free_run", outs(), aligned(e));
      next_cycle();
    end

    // Enable low with stage 0 at C=2 stretches the period.
    sample();
    check("pre_hold", outs(), aligned(0));
    next_cycle();
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample();
      check("enable_hold", outs(), 8'b00_000_111);
      next_cycle();
    end
    enable = 1'b1;
    for (int e = 1; e < 5; e++) begin
      sample();
      check("resume", outs(), aligned(e));
      next_cycle();
    end

    // Load divisor 7 two cycles before the wrap; current period finishes at 4.
    div_in   = {8'd4, 8'd4, 8'd7};
    div_load = 1'b1;
    s0_exp   = 11'b01000000100;
    p0_exp   = 11'b10001111001;
    for (int i = 0; i < 11; i++) begin
      sample();
      check("div7", outs(), {2'b00, 2'b00, s0_exp[i], 1'b1, (i < 3), p0_exp[i]});
      next_cycle();
      div_load = 1'b0;
    end
    for (int i = 0; i < 5; i++) begin
      sample();
      check("div7_tail", {5'd0, strobe_out}, 8'd0);
      next_cycle();
    end

    // Load divisor 2 in the wrap cycle itself.
    div_in   = {8'd4, 8'd4, 8'd2};
    div_load = 1'b1;
    sample();
    check("wrap_load", outs(), 8'b00_011_100);
    next_cycle();
    div_load  = 1'b0;
    d2_exp[0] = 8'b00_000_111;
    d2_exp[1] = 8'b00_001_110;
    d2_exp[2] = 8'b00_000_111;
    d2_exp[3] = 8'b00_001_110;
    for (int i = 0; i < 4; i++) begin
      sample();
      check("div2", outs(), d2_exp[i]);
      next_cycle();
    end
    sample();
    next_cycle();

    // Clear with a same-cycle load sets stage 1 to divisor 0; the wrap strobe is suppressed.
    div_in     = {8'd4, 8'd0, 8'd2};
    div_load   = 1'b1;
    sync_clear = 1'b1;
    sample();
    check("clear_load", {5'd0, strobe_out}, 8'd0);
    next_cycle();
    div_load   = 1'b0;
    sync_clear = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (i == 6) begin
        div_in   = {8'd4, 8'd1, 8'd2};
        div_load = 1'b1;
      end
      s = (i % 2 == 1);
      sample();
      check("div0_1", {5'd0, strobe_out[1], strobe_out[0], phase_out[1]}, {5'd0, s, s, 1'b1});
      next_cycle();
      div_load = 1'b0;
    end

    // Restore divide-by-4, then sync_clear alone in a wrap cycle.
    div_in   = {8'd4, 8'd4, 8'd4};
    div_load = 1'b1;
    sample();
    next_cycle();
    div_load   = 1'b0;
    sync_clear = 1'b1;
    sample();
    check("clear_alone", {5'd0, strobe_out}, 8'd0);
    next_cycle();
    sync_clear = 1'b0;
    for (int e = 0; e < 15; e++) begin
      sample();
      check("realigned", outs(), aligned(e));
      next_cycle();
    end
    sample();
    check("pre_reset", outs(), aligned(15));
    #1 reset_n = 1'b0;
    #1 check("reset_midcount", outs(), 8'b00_000_111);
    next_cycle();
    reset_n = 1'b1;
    sample();
    check("post_reset0", outs(), aligned(0));
    next_cycle();
    sample();
    check("post_reset1", outs(), aligned(1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
